// File: rtl/onehot_pkg.sv
// rtl/onehot_pkg.sv - shared types and helpers for the one-hot sequence generator
package onehot_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    GAP  = 2'd2
  } state_t;

  // Widest code the helpers accept; callers zero-extend narrower codes.
  localparam int MAX_W = 64;

  typedef struct packed {
    logic        wrapped;
    logic [31:0] next_idx;
  } rot_t;

  function automatic logic is_onehot(input logic [MAX_W-1:0] v);
    int n;
    n = 0;
    for (int i = 0; i < MAX_W; i++) n += int'(v[i]);
    return (n == 1);
  endfunction

  function automatic logic is_onehot0(input logic [MAX_W-1:0] v);
    int n;
    n = 0;
    for (int i = 0; i < MAX_W; i++) n += int'(v[i]);
    return (n <= 1);
  endfunction

  // dir=0 moves toward the MSB, dir=1 toward the LSB; wrapped marks the end-around step.
  function automatic rot_t rot_idx(input logic [31:0] idx, input logic dir, input int w);
    rot_t r;
    if (!dir) begin
      r.wrapped  = (idx == 32'(w - 1));
      r.next_idx = r.wrapped ? 32'd0 : idx + 32'd1;
    end else begin
      r.wrapped  = (idx == 32'd0);
      r.next_idx = r.wrapped ? 32'(w - 1) : idx - 32'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/onehot_seq_gen_if.sv
// rtl/onehot_seq_gen_if.sv - control and output bundle of the one-hot generator
interface onehot_seq_gen_if #(
  parameter int W  = 4,
  parameter int CW = 16
);
  localparam int IW = $clog2(W);

  logic          start;
  logic [IW-1:0] start_idx;
  logic          stop;
  logic          dir;
  logic          allow_zero;
  logic          out_ready;
  logic          out_valid;
  logic [W-1:0]  code;
  logic [IW-1:0] idx;
  logic          wrap;
  logic [CW-1:0] xfer_cnt;
  logic [CW-1:0] wrap_cnt;
  logic          err;

  modport master (
    input  start, start_idx, stop, dir, allow_zero, out_ready,
    output out_valid, code, idx, wrap, xfer_cnt, wrap_cnt, err
  );

  modport slave (
    output start, start_idx, stop, dir, allow_zero, out_ready,
    input  out_valid, code, idx, wrap, xfer_cnt, wrap_cnt, err
  );
endinterface

// File: rtl/onehot_check.sv
// rtl/onehot_check.sv - combinational one-hot rule checker on registered outputs
module onehot_check
  import onehot_pkg::*;
#(
  parameter int W = 4
) (
  input  logic [W-1:0] code,
  input  state_t       state,
  input  logic         out_valid,
  output logic         violation
);

  // RUN must be exactly one-hot, GAP all-zero, and nothing else may claim valid.
  always_comb begin
    violation = 1'b0;
    case (state)
      RUN:     violation = !is_onehot(MAX_W'(code));
      GAP:     violation = (code != '0);
      default: violation = out_valid;
    endcase
  end

endmodule

// File: rtl/onehot_seq_gen.sv
// rtl/onehot_seq_gen.sv - rotating one-hot code producer with gap insertion and self-check
module onehot_seq_gen
  import onehot_pkg::*;
#(
  parameter  int W  = 4,
  parameter  int CW = 16,
  localparam int IW = $clog2(W)
) (
  input logic              clk,
  input logic              rst,
  onehot_seq_gen_if.master bus
);

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [W-1:0]  code_q, code_d;
  logic          valid_q, valid_d;
  logic          wrap_q, wrap_d;
  logic [CW-1:0] xfer_q, xfer_d;
  logic [CW-1:0] wrapc_q, wrapc_d;
  logic          stop_pend_q, stop_pend_d;
  logic          err_q;
  logic          violation;

  rot_t          rot;
  logic          hs;
  logic          stopping;
  logic [IW-1:0] start_pos;
  logic [IW-1:0] rot_pos;

  assign hs        = valid_q & bus.out_ready;
  assign stopping  = bus.stop | stop_pend_q;
  assign rot       = rot_idx(32'(idx_q), bus.dir, W);
  assign rot_pos   = IW'(rot.next_idx);
  assign start_pos = (32'(bus.start_idx) < W) ? bus.start_idx : '0;

  assign bus.out_valid = valid_q;
  assign bus.code      = code_q;
  assign bus.idx       = idx_q;
  assign bus.wrap      = wrap_q;
  assign bus.xfer_cnt  = xfer_q;
  assign bus.wrap_cnt  = wrapc_q;
  assign bus.err       = err_q;

  onehot_check #(.W(W)) u_check (
    .code      (bus.code),
    .state     (state_q),
    .out_valid (valid_q),
    .violation (violation)
  );

  // Next-state and next-output decode; a pending stop ends the flow at the next handshake.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    code_d      = code_q;
    valid_d     = valid_q;
    wrap_d      = 1'b0;
    xfer_d      = xfer_q;
    wrapc_d     = wrapc_q;
    stop_pend_d = stop_pend_q;
    case (state_q)
      IDLE: begin
        stop_pend_d = 1'b0;
        if (bus.start) begin
          state_d = RUN;
          idx_d   = start_pos;
          code_d  = W'(1) << start_pos;
          valid_d = 1'b1;
        end
      end
      RUN: begin
        if (bus.stop) stop_pend_d = 1'b1;
        if (hs) begin
          xfer_d = xfer_q + CW'(1);
          idx_d  = rot_pos;
          if (rot.wrapped) begin
            wrap_d  = 1'b1;
            wrapc_d = wrapc_q + CW'(1);
          end
          if (stopping) begin
            state_d     = IDLE;
            valid_d     = 1'b0;
            code_d      = '0;
            stop_pend_d = 1'b0;
          end else if (rot.wrapped && bus.allow_zero) begin
            state_d = GAP;
            code_d  = '0;
          end else begin
            code_d = W'(1) << rot_pos;
          end
        end
      end
      GAP: begin
        if (bus.stop) stop_pend_d = 1'b1;
        if (hs) begin
          xfer_d = xfer_q + CW'(1);
          if (stopping) begin
            state_d     = IDLE;
            valid_d     = 1'b0;
            code_d      = '0;
            stop_pend_d = 1'b0;
          end else begin
            state_d = RUN;
            code_d  = W'(1) << idx_q;
          end
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        code_d  = '0;
      end
    endcase
  end

  // State and output registers; err accumulates checker violations until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      code_q      <= '0;
      valid_q     <= 1'b0;
      wrap_q      <= 1'b0;
      xfer_q      <= '0;
      wrapc_q     <= '0;
      stop_pend_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      code_q      <= code_d;
      valid_q     <= valid_d;
      wrap_q      <= wrap_d;
      xfer_q      <= xfer_d;
      wrapc_q     <= wrapc_d;
      stop_pend_q <= stop_pend_d;
      err_q       <= err_q | violation;
    end
  end

endmodule

// File: doc/onehot_seq_gen.md
Name: onehot_seq_gen

Overview:
- Producer side of the one-hot code path: generates a rotating one-hot code on a W-bit bus for downstream blocks and checkers (`$onehot` / `$onehot0` consumers).
- Output uses a valid/ready handshake.
- Rotation direction is selectable per transfer.
- An optional all-zero "gap" code is inserted at each wrap to exercise `$onehot0` paths.
- A sticky internal self-check flags any emitted code that violates the one-hot rules.

Parameters:
- W, 4, code width in bits; W >= 2.
- IW, $clog2(W), index width; derived, not overridden.
- CW, 16, width of transfer and wrap counters.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin sequencing; honoured only in IDLE.
- start_idx  in  IW  initial hot-bit position; values >= W are treated as 0.
- stop  in  1  end sequencing after the current transfer.
- dir  in  1  0 = rotate left (idx+1), 1 = rotate right (idx-1); sampled at each handshake.
- allow_zero  in  1  enables the all-zero gap code at wrap; sampled at wrap handshake.
- out_ready  in  1  downstream ready.
- out_valid  out  1  code valid.
- code  out  W  current code.
- idx  out  IW  position of the hot bit; holds the pending index during GAP.
- wrap  out  1  one-cycle pulse on a wrapping handshake.
- xfer_cnt  out  CW  completed handshakes, modulo 2^CW.
- wrap_cnt  out  CW  completed wraps, modulo 2^CW.
- err  out  1  sticky self-check failure.

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE, out_valid=0, code=0, idx=0, wrap=0, xfer_cnt=0, wrap_cnt=0, err=0.
- Reset mid-transfer aborts immediately; there is no drain.
- All outputs are registered.
- States: IDLE, RUN, GAP.
- IDLE:
  - out_valid=0, code=0.
  - start=1 → next cycle RUN, idx=start_idx (clamped), code=1<<idx, out_valid=1.
  - stop is ignored in IDLE; start together with stop → start wins.
- RUN:
  - out_valid=1; code=1<<idx.
  - code, idx and out_valid hold stable while out_ready=0 (no retraction).
- Handshake = out_valid & out_ready. On each handshake, xfer_cnt increments.
- Next index on a RUN handshake:
  - Left: idx==W-1 → 0 (wrap).
  - Right: idx==0 → W-1 (wrap).
  - Otherwise idx±1, no wrap.
- Wrapping handshake in RUN:
  - wrap=1 for exactly the next cycle; wrap_cnt increments.
  - allow_zero=1 → GAP; idx updates to the wrapped value; code=0; out_valid=1.
  - allow_zero=0 → stay in RUN with the wrapped code.
- GAP:
  - Emits code=0 with out_valid=1, held until handshake.
  - Handshake → RUN with code=1<<idx; no rotation and no wrap on this transfer.
  - dir is not applied on a GAP handshake.
- stop:
  - stop=1 sampled high in RUN or GAP sets a pending-stop latch.
  - At the next handshake (including the same cycle as the stop), the transfer completes, counters update, and the next state is IDLE: out_valid=0, code=0.
  - A wrap pulse is still generated if that last transfer wrapped.
  - GAP is never entered on a stopping transfer.
- Back-to-back: with out_ready=1 held, one transfer per cycle, zero bubbles in RUN. GAP costs exactly one transfer slot.
- Self-check, evaluated every cycle on registered outputs:
  - err sets if (state==RUN and code is not exactly one-hot), or (state==GAP and code!=0), or (state==IDLE and out_valid==1).
  - err is sticky until rst.
- Counter wrap: CW-bit counters roll 2^CW-1 → 0 silently.

Decomposition:
- Package onehot_pkg holds:
  - state enum state_t {IDLE, RUN, GAP};
  - function is_onehot(logic [W-1:0]);
  - function is_onehot0(logic [W-1:0]);
  - function rot_idx(idx, dir, W) returning {wrapped, next_idx}.
- One sub-module, onehot_check: purely combinational (code, state, out_valid) → violation. It is instantiated in the top module, with err registered in the top module.
- Rotation and FSM stay in the top module.

Test Plan (W=4):
- Reset, then start=1, start_idx=0, dir=0, out_ready=1 for 6 cycles → codes 0001,0010,0100,1000,0001,0010; wrap pulses once after the 1000 handshake; xfer_cnt=6 after the 6th handshake; err=0.
- start_idx=2, dir=1, allow_zero=1, out_ready=1 → codes 0100,0010,0001,0000,1000,0100; wrap_cnt=1; the GAP code 0000 has out_valid=1.
- Backpressure: in RUN with code=0010, out_ready=0 for 5 cycles → code/idx/out_valid stable for all 5 cycles; out_ready=1 → next code 0100; xfer_cnt increments by 1 only.
- stop=1 in the same cycle as the handshake on code=1000, dir=0, allow_zero=1 → next cycle IDLE, out_valid=0, code=0000, wrap=1, no GAP emitted.
- start_idx=3 with W=4 → first code 1000. Force an out-of-range start_idx via W=3 and start_idx=3 → first code 001.
- rst asserted mid-RUN (code=0100, xfer_cnt=2) → next cycle all outputs at reset values. Separately, a bench force of code=0110 in RUN → err=1 and remains 1 until rst.
